// File: rtl/packet_framer.sv
// packet_framer: turns a (target, size) command plus a payload stream into the checksummed
// Hermes flit sequence ADDR, SIZE, payload... for the router local input port.
// Ports: clk/reset (sync, active-low); cmd_valid/cmd_ready/cmd_target/cmd_size command in;
//   pl_valid/pl_ready/pl_data payload in; tx/data_out/credit_i flit out (credit handshake);
//   busy (not IDLE), err_o (size-0 command dropped), pad_o (payload padding started).
`timescale 1ns/1ps
module packet_framer #(
   parameter logic [7:0] XMax       = 8'd3,
   parameter logic [7:0] YMax       = 8'd3,
   parameter int         TimeoutMax = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [15:0] cmd_target,
   input  logic [23:0] cmd_size,
   input  logic        pl_valid,
   output logic        pl_ready,
   input  logic [31:0] pl_data,
   output logic        tx,
   output logic [31:0] data_out,
   input  logic        credit_i,
   output logic        busy,
   output logic        err_o,
   output logic        pad_o
);
   localparam int         TW = $clog2(TimeoutMax + 1);
   localparam logic [15:0] IV = {XMax, YMax};

   typedef enum logic [2:0] {IDLE, ADDR, SIZE, PAYLOAD, PAD} state_t;

   state_t        state, state_n;
   logic          tx_n;
   logic [31:0]   data_n;
   logic [23:0]   rem, rem_n;
   logic [TW-1:0] tcnt, tcnt_n;
   logic [15:0]   tgt_q, tgt_n;
   logic [23:0]   sz_q, sz_n;
   logic          err_n, pad_n;
   logic          load_ok;

   function automatic logic [7:0] addr_chk(input logic [15:0] t);
      logic [7:0] c;
      c = '0;
      for (int i = 0; i < 8; i++)
         c[i] = t[2*i] ^ t[2*i+1] ^ IV[2*i] ^ IV[2*i+1];
      return c;
   endfunction

   function automatic logic [7:0] size_chk(input logic [23:0] s, input logic [7:0] a);
      logic [7:0] c;
      c = '0;
      for (int i = 0; i < 8; i++)
         c[i] = s[3*i] ^ s[3*i+1] ^ s[3*i+2] ^ a[i];
      return c;
   endfunction

   // The output register can take a new flit when empty or being consumed this cycle.
   assign load_ok = !tx || credit_i;
   assign busy    = (state != IDLE);

   always_comb begin
      state_n   = state;
      tx_n      = tx && !credit_i;
      data_n    = data_out;
      rem_n     = rem;
      tcnt_n    = tcnt;
      tgt_n     = tgt_q;
      sz_n      = sz_q;
      err_n     = 1'b0;
      pad_n     = 1'b0;
      cmd_ready = 1'b0;
      pl_ready  = 1'b0;
      case (state)
         IDLE: begin
            cmd_ready = reset;
            tcnt_n    = '0;
            if (cmd_valid && reset) begin
               if (cmd_size == 24'd0) begin
                  err_n = 1'b1;
               end else begin
                  tgt_n   = cmd_target;
                  sz_n    = cmd_size;
                  data_n  = {8'h00, addr_chk(cmd_target), cmd_target};
                  tx_n    = 1'b1;
                  rem_n   = cmd_size;
                  state_n = ADDR;
               end
            end
         end
         ADDR: begin
            if (credit_i) begin
               data_n  = {size_chk(sz_q, addr_chk(tgt_q)), sz_q};
               tx_n    = 1'b1;
               state_n = SIZE;
            end
         end
         SIZE: begin
            // tx drops on consumption, giving exactly one bubble before payload.
            if (credit_i)
               state_n = PAYLOAD;
         end
         PAYLOAD: begin
            pl_ready = reset && (rem != 24'd0) && load_ok;
            if (pl_ready && pl_valid) begin
               data_n = pl_data;
               tx_n   = 1'b1;
               rem_n  = rem - 24'd1;
               tcnt_n = '0;
            end else if (pl_ready) begin
               // Source starving while we could accept: count toward padding.
               if (tcnt == TW'(TimeoutMax - 1)) begin
                  tcnt_n  = '0;
                  pad_n   = 1'b1;
                  state_n = PAD;
               end else begin
                  tcnt_n = tcnt + TW'(1);
               end
            end else begin
               // Downstream backpressure never counts as starvation.
               tcnt_n = '0;
            end
            if (rem == 24'd0 && load_ok)
               state_n = IDLE;
         end
         PAD: begin
            // A payload flit still held in the register drains first via load_ok.
            if (load_ok) begin
               if (rem != 24'd0) begin
                  data_n = 32'h0;
                  tx_n   = 1'b1;
                  rem_n  = rem - 24'd1;
               end else begin
                  state_n = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         tx       <= 1'b0;
         data_out <= 32'h0;
         rem      <= '0;
         tcnt     <= '0;
         tgt_q    <= '0;
         sz_q     <= '0;
         err_o    <= 1'b0;
         pad_o    <= 1'b0;
      end else begin
         state    <= state_n;
         tx       <= tx_n;
         data_out <= data_n;
         rem      <= rem_n;
         tcnt     <= tcnt_n;
         tgt_q    <= tgt_n;
         sz_q     <= sz_n;
         err_o    <= err_n;
         pad_o    <= pad_n;
      end
   end
endmodule

// File: tb/tb_packet_framer.sv
`timescale 1ns/1ps
module tb_packet_framer;
   localparam int TMAX = 10;

   logic        clk;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [15:0] cmd_target;
   logic [23:0] cmd_size;
   logic        pl_valid;
   logic        pl_ready;
   logic [31:0] pl_data;
   logic        tx;
   logic [31:0] data_out;
   logic        credit_i;
   logic        busy;
   logic        err_o;
   logic        pad_o;

   packet_framer #(.XMax(8'd3), .YMax(8'd3), .TimeoutMax(TMAX)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_target(cmd_target), .cmd_size(cmd_size),
      .pl_valid(pl_valid), .pl_ready(pl_ready), .pl_data(pl_data),
      .tx(tx), .data_out(data_out), .credit_i(credit_i),
      .busy(busy), .err_o(err_o), .pad_o(pad_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc_cnt = 0;
   int hold_err = 0;
   int proto_err = 0;
   logic        hold_prev = 1'b0;
   logic [31:0] hold_dat  = 32'h0;
   logic [31:0] got[$];
   int          got_cyc[$];

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   // Flit monitor: records every consumed flit and checks held flits stay stable.
   always @(negedge clk) begin
      if (tx && credit_i) begin
         got.push_back(data_out);
         got_cyc.push_back(cyc_cnt);
      end
      if (hold_prev && (!tx || data_out !== hold_dat)) hold_err++;
      hold_prev = tx && !credit_i && reset;
      hold_dat  = data_out;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic run_pkt(input logic [15:0] t, input logic [23:0] s, input int nvalid,
                          input int st1, input int st2, input int rst_at,
                          output int n_pad, output int acc_last, output int pad_at,
                          output int end_at, output logic end_tx, output int tout);
      int sent;
      sent = 0; n_pad = 0; acc_last = -1; pad_at = -1; end_at = -1; end_tx = 1'b1; tout = 1;
      got.delete(); got_cyc.delete();
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_target = t; cmd_size = s; credit_i = 1'b1;
      pl_valid = (nvalid > 0); pl_data = 32'hAAAA0001;
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         if (pl_valid && pl_ready) begin sent++; acc_last = cyc_cnt; end
         if (pad_o) begin n_pad++; pad_at = cyc_cnt; end
         if (busy && cmd_ready) proto_err++;
         if (c > 0 && !busy) begin
            end_at = cyc_cnt; end_tx = tx; tout = 0;
            break;
         end
         @(posedge clk); #1;
         cmd_valid = 1'b0;
         credit_i  = !((st1 >= 0 && c + 1 >= st1 && c + 1 < st1 + 5) ||
                       (st2 >= 0 && c + 1 >= st2 && c + 1 < st2 + 5));
         pl_valid  = (sent < nvalid);
         pl_data   = 32'hAAAA0001 + 32'(sent);
         reset     = !(c == rst_at);
      end
   endtask

   typedef struct {
      logic [15:0] t;
      logic [23:0] s;
      int          nvalid;
      int          st1;
      int          st2;
      logic [31:0] exp_a;
      logic [31:0] exp_s;
      int          exp_pad;
   } vec_t;

   vec_t tbl[8];
   logic [31:0] exp_q[$];

   initial begin
      int n_pad, acc_last, pad_at, end_at, tout;
      logic end_tx;

      tbl[0] = '{16'h0102, 24'd3,  3,  -1, -1, 32'h00110102, 32'h11000003, 0};
      tbl[1] = '{16'h0000, 24'd1,  1,  -1, -1, 32'h00000000, 32'h01000001, 0};
      tbl[2] = '{16'hFFFF, 24'd2,  2,  -1, -1, 32'h0000FFFF, 32'h01000002, 0};
      tbl[3] = '{16'h0001, 24'd2,  2,  -1, -1, 32'h00010001, 32'h00000002, 0};
      tbl[4] = '{16'h8000, 24'd7,  7,  -1, -1, 32'h00808000, 32'h81000007, 0};
      tbl[5] = '{16'h0003, 24'd64, 64, -1, -1, 32'h00000003, 32'h04000040, 0};
      tbl[6] = '{16'h0102, 24'd4,  4,  1,  10, 32'h00110102, 32'h10000004, 0};
      tbl[7] = '{16'h0102, 24'd5,  2,  -1, -1, 32'h00110102, 32'h11000005, 1};

      reset = 1'b0; cmd_valid = 1'b0; cmd_target = '0; cmd_size = '0;
      pl_valid = 1'b0; pl_data = '0; credit_i = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst tx", 32'(tx), 32'd0);
      chk("rst data_out", data_out, 32'h0);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst err_o", 32'(err_o), 32'd0);
      chk("rst pad_o", 32'(pad_o), 32'd0);
      chk("rst cmd_ready", 32'(cmd_ready), 32'd0);
      chk("rst pl_ready", 32'(pl_ready), 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      chk("idle cmd_ready", 32'(cmd_ready), 32'd1);

      for (int v = 0; v < 8; v++) begin
         run_pkt(tbl[v].t, tbl[v].s, tbl[v].nvalid, tbl[v].st1, tbl[v].st2, -1,
                 n_pad, acc_last, pad_at, end_at, end_tx, tout);
         pl_valid = 1'b0;
         chk($sformatf("v%0d finished", v), 32'(tout), 32'd0);
         exp_q.delete();
         exp_q.push_back(tbl[v].exp_a);
         exp_q.push_back(tbl[v].exp_s);
         for (int k = 0; k < int'(tbl[v].s); k++)
            exp_q.push_back(k < tbl[v].nvalid ? 32'hAAAA0001 + 32'(k) : 32'h0);
         chk($sformatf("v%0d flit count", v), 32'(got.size()), 32'(exp_q.size()));
         for (int k = 0; k < exp_q.size() && k < got.size(); k++)
            chk($sformatf("v%0d flit %0d", v, k), got[k], exp_q[k]);
         chk($sformatf("v%0d pad pulses", v), 32'(n_pad), 32'(tbl[v].exp_pad));
         if (tbl[v].exp_pad != 0)
            chk($sformatf("v%0d pad delay", v), 32'(pad_at - acc_last), 32'(TMAX + 1));
         if (tbl[v].st1 < 0 && tbl[v].st2 < 0 && got_cyc.size() > 3) begin
            chk($sformatf("v%0d bubble", v), 32'(got_cyc[2] - got_cyc[1]), 32'd2);
            if (tbl[v].nvalid > 1)
               chk($sformatf("v%0d back2back", v), 32'(got_cyc[3] - got_cyc[2]), 32'd1);
         end
         if (got_cyc.size() > 0)
            chk($sformatf("v%0d busy fall", v), 32'(end_at - got_cyc[$]), 32'd1);
      end

      // Size-0 command is dropped with an error pulse.
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_target = 16'h0102; cmd_size = 24'd0;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      @(negedge clk);
      chk("size0 err_o", 32'(err_o), 32'd1);
      chk("size0 tx", 32'(tx), 32'd0);
      chk("size0 cmd_ready", 32'(cmd_ready), 32'd1);
      chk("size0 busy", 32'(busy), 32'd0);
      @(negedge clk);
      chk("size0 err_o one-shot", 32'(err_o), 32'd0);

      // Reset during PAYLOAD abandons the packet.
      run_pkt(16'h0102, 24'd8, 8, -1, -1, 6, n_pad, acc_last, pad_at, end_at, end_tx, tout);
      pl_valid = 1'b0;
      chk("rstmid abandoned", 32'(tout), 32'd0);
      chk("rstmid tx", 32'(end_tx), 32'd0);
      chk("rstmid flits before", 32'(got.size()), 32'd6);
      repeat (6) @(negedge clk);
      chk("rstmid no late flit", 32'(got.size()), 32'd6);
      run_pkt(tbl[0].t, tbl[0].s, 3, -1, -1, -1, n_pad, acc_last, pad_at, end_at, end_tx, tout);
      pl_valid = 1'b0;
      chk("post-rst finished", 32'(tout), 32'd0);
      chk("post-rst flit count", 32'(got.size()), 32'd5);
      if (got.size() == 5) begin
         chk("post-rst addr", got[0], 32'h00110102);
         chk("post-rst size", got[1], 32'h11000003);
         chk("post-rst last", got[4], 32'hAAAA0003);
      end

      chk("held flits stable", 32'(hold_err), 32'd0);
      chk("cmd_ready low while busy", 32'(proto_err), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
